aes_round_sched: RTL
====================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NR, default 10, number of cipher rounds; legal values 10, 12, 14.
REQ-002 SHALL have parameter NK, default 4, key length in 32-bit words; legal values 4, 6, 8, with NR = NK+6.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset sampled on the clk rising edge.
REQ-005 SHALL have port req_valid, input, 2, per-requester block-available flag (bit i = requester i).
REQ-006 SHALL have port req_ready, output, 2, per-requester accept flag.
REQ-007 SHALL have port req_data0 / req_data1, input, 128 each, plaintext block from requester 0 / 1.
REQ-008 SHALL have port dp_load, output, 1, datapath control: load dp_data XOR round key 0.
REQ-009 SHALL have port dp_step, output, 1, datapath control: apply one full round.
REQ-010 SHALL have port dp_final, output, 1, datapath control: apply final round (no MixColumns).
REQ-011 SHALL have port dp_data, output, 128, captured plaintext block driven to the datapath.
REQ-012 SHALL have port key_idx, output, 4, round-key index selected from the expanded key schedule.
REQ-013 SHALL have port dp_state, input, 128, current datapath state register.
REQ-014 SHALL have port resp_valid, output, 1, ciphertext-available flag.
REQ-015 SHALL have port resp_ready, input, 1, consumer accept flag.
REQ-016 SHALL have port resp_data, output, 128, ciphertext (pass-through of dp_state while resp_valid).
REQ-017 SHALL have port resp_id, output, 1, index of requester owning the current block.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-019 SHALL have port blk_cnt, output, 16, count of completed response handshakes.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, DONE.
REQ-021 In IDLE, SHALL assert req_ready for exactly one requester: the one with req_valid set; if both set, the one not granted most recently (round-robin); if neither, req_ready = 0.
REQ-022 req_ready SHALL be 0 in every state other than IDLE.
REQ-023 On acceptance (req_valid[i] & req_ready[i] in cycle A), SHALL capture req_data i into dp_data, capture i into resp_id, update round-robin pointer to i, and enter LOAD at A+1.
REQ-024 LOAD SHALL last 1 cycle with dp_load = 1, key_idx = 0; next state ROUND.
REQ-025 ROUND SHALL last NR-1 cycles (A+2 .. A+NR) with dp_step = 1 and key_idx = 1, 2, ..., NR-1 in successive cycles; next state FINAL.
REQ-026 FINAL SHALL last 1 cycle (A+NR+1) with dp_final = 1, key_idx = NR; next state DONE.
REQ-027 DONE SHALL be entered at A+NR+2 with resp_valid = 1, resp_data = dp_state; held stable until resp_ready = 1.
REQ-028 On resp_valid & resp_ready, SHALL increment blk_cnt (mod 2^16, FFFF wraps to 0000) and return to IDLE next cycle; no new request is accepted in that same cycle.
REQ-029 dp_load, dp_step, dp_final SHALL be mutually exclusive; at most one high per cycle, all 0 in IDLE and DONE.
REQ-030 key_idx SHALL be 0 in IDLE and DONE.
REQ-031 Requester req_valid changes while busy SHALL have no effect; a requester left waiting SHALL be granted in the next IDLE cycle if still valid.
REQ-032 resp_data SHALL be 0 whenever resp_valid = 0.

Reset
REQ-033 When reset = 0 at a rising edge, SHALL enter IDLE irrespective of state, including mid-round or in DONE.
REQ-034 Reset values: req_ready 00 (combinational with IDLE), dp_load/dp_step/dp_final 0, key_idx 0, dp_data 0, resp_valid 0, resp_data 0, resp_id 0, busy 0, blk_cnt 0, round-robin pointer = 1 (requester 0 wins first tie).
REQ-035 An in-flight block interrupted by reset SHALL be discarded; no response, no blk_cnt change.

Verification
REQ-036 NR=10, req_valid=01, data0=00112233445566778899AABBCCDDEEFF, datapath with FIPS-197 key 000102..0F -> resp_valid at A+12, resp_data=69C4E0D86A7B0430D8CDB78070B4C55A, resp_id=0.
REQ-037 Key sequencing NR=10: key_idx traces 0,1,2,...,9,10 over cycles A+1..A+11 with dp_load only at A+1, dp_final only at A+11.
REQ-038 req_valid=11 held continuously, resp_ready=1 -> grants alternate 0,1,0,1; resp_id alternates; blk_cnt reaches 4 after four responses.
REQ-039 resp_ready=0 for 5 cycles in DONE -> resp_valid and resp_data stable 5 cycles, req_ready=00, blk_cnt unchanged until handshake.
REQ-040 reset=0 asserted at A+5 -> next cycle busy=0, all controls 0, no response produced; subsequent request completes normally.
REQ-041 NR=14, NK=8 -> ROUND lasts 13 cycles, key_idx ends at 14, resp_valid at A+16.

Source files
------------

// File: rtl/aes_round_sched.sv
// Control scheduler for an iterative AES encryption datapath. It arbitrates two
// requesters round-robin, sequences load/round/final steps with round-key indices,
// and returns the ciphertext to the consumer.
module aes_round_sched #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    output logic         dp_load,
    output logic         dp_step,
    output logic         dp_final,
    output logic [127:0] dp_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] dp_state,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         resp_id,
    output logic         busy,
    output logic [15:0]  blk_cnt
);

    localparam logic [3:0] KEY_LAST_ROUND = 4'(NR - 1);
    localparam logic [3:0] KEY_FINAL      = 4'(NR);

    // Only the three standard AES key sizes are meaningful here.
    if ((NR != NK + 6) || ((NK != 4) && (NK != 6) && (NK != 8))) begin : g_bad_params
        $error("aes_round_sched: illegal NR/NK combination");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    key_idx_r;
    logic [3:0]    key_idx_s;
    logic          load_r;
    logic          load_s;
    logic          step_r;
    logic          step_s;
    logic          final_r;
    logic          final_s;
    logic          busy_r;
    logic          resp_valid_r;
    logic [127:0]  dp_data_r;
    logic          resp_id_r;
    logic          rr_ptr_r;
    logic [15:0]   blk_cnt_r;
    logic          grant_valid_s;
    logic          grant_id_s;
    logic          resp_hs_s;

    // Round-robin grant, only offered while idle; a tie goes to the requester not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (state_r == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_id_s    = ~rr_ptr_r;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_id_s    = 1'b0;
                end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Decode the grant into the one-hot ready vector.
    always_comb begin
        req_ready = 2'b00;
        if (grant_valid_s) begin
            req_ready = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign resp_hs_s = (state_r == DONE) && resp_ready;

    // Next state plus the datapath controls that go with it, so the controls can be registered.
    always_comb begin
        state_s   = state_r;
        key_idx_s = 4'd0;
        load_s    = 1'b0;
        step_s    = 1'b0;
        final_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = LOAD;
                    load_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s   = ROUND;
                step_s    = 1'b1;
                key_idx_s = 4'd1;
            end
            ROUND: begin
                if (key_idx_r == KEY_LAST_ROUND) begin
                    state_s   = FINAL;
                    final_s   = 1'b1;
                    key_idx_s = KEY_FINAL;
                end else begin
                    state_s   = ROUND;
                    step_s    = 1'b1;
                    key_idx_s = key_idx_r + 4'd1;
                end
            end
            FINAL: begin
                state_s = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, registered controls and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            key_idx_r    <= 4'd0;
            load_r       <= 1'b0;
            step_r       <= 1'b0;
            final_r      <= 1'b0;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            key_idx_r    <= key_idx_s;
            load_r       <= load_s;
            step_r       <= step_s;
            final_r      <= final_s;
            busy_r       <= (state_s != IDLE);
            resp_valid_r <= (state_s == DONE);
        end
    end

    // Capture the granted block and its owner; the pointer remembers who was served last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_data_r <= 128'd0;
            resp_id_r <= 1'b0;
            rr_ptr_r  <= 1'b1;
        end else if (grant_valid_s) begin
            dp_data_r <= grant_id_s ? req_data1 : req_data0;
            resp_id_r <= grant_id_s;
            rr_ptr_r  <= grant_id_s;
        end else begin
            dp_data_r <= dp_data_r;
            resp_id_r <= resp_id_r;
            rr_ptr_r  <= rr_ptr_r;
        end
    end

    // Completed-block counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blk_cnt_r <= 16'd0;
        end else if (resp_hs_s) begin
            blk_cnt_r <= blk_cnt_r + 16'd1;
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    // Ciphertext is the live datapath state, gated to zero outside a valid response.
    always_comb begin
        resp_data = 128'd0;
        if (resp_valid_r) begin
            resp_data = dp_state;
        end else begin
            resp_data = 128'd0;
        end
    end

    assign dp_load    = load_r;
    assign dp_step    = step_r;
    assign dp_final   = final_r;
    assign key_idx    = key_idx_r;
    assign dp_data    = dp_data_r;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign busy       = busy_r;
    assign blk_cnt    = blk_cnt_r;

endmodule
